// File: rtl/ones_count_seq.sv
// Sequential ones counter: accepts a WIDTH-bit word, counts CHUNK bits per clock and
// hands the count off on valid/ready, keeping a saturating running total.
// Optional threshold compare output is enabled by defining ONES_COUNT_THRESH_EN.
module ones_count_seq #(
    parameter int WIDTH = 7,
    parameter int CHUNK = 2,
    parameter int ACC_W = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    input  logic             acc_clear,
    output logic [ACC_W-1:0] acc_total
`ifdef ONES_COUNT_THRESH_EN
    ,
    input  logic [CW-1:0]    thresh,
    output logic             out_ge
`endif
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SW     = ACC_W + CW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_n;
    logic [PW-1:0]   data_r;
    logic [IW-1:0]   idx_r;
    logic [CW-1:0]   sum_r;
    logic [CW-1:0]   sum_next_s;
    logic            load_s;
    logic            step_s;
    logic            last_s;
    logic            handoff_s;

    function automatic logic [CW-1:0] chunk_ones(input logic [CHUNK-1:0] c);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + CW'(c[i]);
        end
        return n;
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [CW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > SW'({ACC_W{1'b1}})) begin
            return {ACC_W{1'b1}};
        end else begin
            return s[ACC_W-1:0];
        end
    endfunction

    // The word is shifted right each step, so the current chunk is always the low CHUNK bits.
    assign sum_next_s = sum_r + chunk_ones(data_r[CHUNK-1:0]);
    assign last_s     = (idx_r == IW'(NCHUNK - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_n   = state_r;
        load_s    = 1'b0;
        step_s    = 1'b0;
        handoff_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    load_s  = 1'b1;
                    state_n = COUNT;
                end else begin
                    state_n = IDLE;
                end
            end
            COUNT: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_n = DONE;
                end else begin
                    state_n = COUNT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    handoff_s = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath, handshake flags and running total; flags follow the next state so they stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            acc_total <= '0;
            data_r    <= '0;
            idx_r     <= '0;
            sum_r     <= '0;
`ifdef ONES_COUNT_THRESH_EN
            out_ge    <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            if (load_s) begin
                data_r <= PW'(in_data);
                idx_r  <= '0;
                sum_r  <= '0;
            end else if (step_s) begin
                data_r <= data_r >> CHUNK;
                idx_r  <= idx_r + IW'(1);
                sum_r  <= sum_next_s;
                if (last_s) begin
                    out_count <= sum_next_s;
`ifdef ONES_COUNT_THRESH_EN
                    out_ge    <= (sum_next_s >= thresh);
`endif
                end
            end
            // Clear takes effect before a coincident handoff adds its count.
            if (handoff_s) begin
                acc_total <= sat_add(acc_clear ? {ACC_W{1'b0}} : acc_total, out_count);
            end else if (acc_clear) begin
                acc_total <= '0;
            end
        end
    end

endmodule
